dcache_write_buffer: RTL and testbench

//  Dirty-line write buffer between DCache eviction logic and the memory Arbiter write port.

---
 rtl/wb_pkg.sv | 7 +
 rtl/wb_match.sv | 31 +++
 rtl/dcache_write_buffer.sv | 161 ++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the dcache write buffer
package wb_pkg;
  localparam int OFFSET_LEN = 6;
  localparam int LINE_W = 1 << (OFFSET_LEN + 3);

  typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_BUSY, WB_GAP} wb_state_e;
endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - Depth-way line tag compare, youngest matching entry wins
module wb_match #(
  parameter int Depth = 4,
  parameter int TW = 26,
  parameter int PW = 2
) (
  input  logic [Depth-1:0]    valid,
  input  logic [Depth*TW-1:0] tags,
  input  logic [TW-1:0]       query,
  input  logic [PW-1:0]       head,
  output logic                hit,
  output logic [PW-1:0]       idx
);

  logic [PW-1:0] slot;

  // Walk oldest to youngest from head so a later (younger) match overrides.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < Depth; k++) begin
      slot = head + PW'(k);
      if (valid[slot] && (tags[slot*TW +: TW] == query)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - dirty-line write buffer with forwarding lookup
module dcache_write_buffer
  import wb_pkg::*;
#(
  parameter int Offset_len = OFFSET_LEN,
  parameter int Depth = 4,
  localparam int LW = 1 << (Offset_len + 3),
  localparam int PW = $clog2(Depth),
  localparam int TW = 32 - Offset_len
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_valid,
  input  logic [31:0]   push_addr,
  input  logic [LW-1:0] push_data,
  output logic          push_ready,
  input  logic [31:0]   lookup_addr,
  output logic          lookup_hit,
  output logic [LW-1:0] lookup_data,
  output logic          empty,
  output logic          d_wvalid,
  output logic [31:0]   d_waddr,
  output logic [LW-1:0] d_wdata,
  input  logic          d_wready
);

  wb_state_e state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0][TW-1:0] tag_q, tag_d;
  logic [LW-1:0] data_q [Depth];
  logic [LW-1:0] data_d [Depth];
  logic d_wvalid_q, d_wvalid_d;
  logic [31:0] d_waddr_q, d_waddr_d;
  logic [LW-1:0] d_wdata_q, d_wdata_d;

  logic head_busy, accept, pop, alloc;
  logic [Depth-1:0] merge_valid;
  logic merge_hit;
  logic [PW-1:0] merge_idx, lookup_idx;
  logic [TW-1:0] push_tag, lookup_tag;
  logic unused_low_bits;

  assign push_tag    = push_addr[31:Offset_len];
  assign lookup_tag  = lookup_addr[31:Offset_len];
  assign unused_low_bits = ^{push_addr[Offset_len-1:0], lookup_addr[Offset_len-1:0]};

  assign push_ready  = (count_q != (PW+1)'(Depth));
  assign empty       = (count_q == '0) && (state_q == WB_IDLE);
  assign accept      = push_valid && push_ready;

  // The head is off-limits to merging from the cycle its data is latched until it is popped.
  assign head_busy   = (state_q == WB_REQ) || (state_q == WB_BUSY) ||
                       ((state_q == WB_IDLE) && (count_q != '0));
  assign merge_valid = valid_q & ~(head_busy ? ({{(Depth-1){1'b0}}, 1'b1} << head_q) : '0);

  wb_match #(.Depth(Depth), .TW(TW), .PW(PW)) u_merge (
    .valid (merge_valid),
    .tags  (tag_q),
    .query (push_tag),
    .head  (head_q),
    .hit   (merge_hit),
    .idx   (merge_idx)
  );

  wb_match #(.Depth(Depth), .TW(TW), .PW(PW)) u_lookup (
    .valid (valid_q),
    .tags  (tag_q),
    .query (lookup_tag),
    .head  (head_q),
    .hit   (lookup_hit),
    .idx   (lookup_idx)
  );

  assign lookup_data = lookup_hit ? data_q[lookup_idx] : '0;
  assign d_wvalid    = d_wvalid_q;
  assign d_waddr     = d_waddr_q;
  assign d_wdata     = d_wdata_q;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    d_wvalid_d = d_wvalid_q;
    d_waddr_d  = d_waddr_q;
    d_wdata_d  = d_wdata_q;
    pop        = 1'b0;
    alloc      = 1'b0;

    case (state_q)
      WB_IDLE: if (count_q != '0) begin
        d_wvalid_d = 1'b1;
        d_waddr_d  = {tag_q[head_q], {Offset_len{1'b0}}};
        d_wdata_d  = data_q[head_q];
        state_d    = WB_REQ;
      end
      WB_REQ: if (!d_wready) begin
        d_wvalid_d = 1'b0;
        state_d    = WB_BUSY;
      end
      WB_BUSY: if (d_wready) begin
        pop     = 1'b1;
        state_d = WB_GAP;
      end
      WB_GAP:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (accept) begin
      if (merge_hit) begin
        data_d[merge_idx] = push_data;
      end else begin
        alloc           = 1'b1;
        valid_d[tail_q] = 1'b1;
        tag_d[tail_q]   = push_tag;
        data_d[tail_q]  = push_data;
        tail_d          = tail_q + 1'b1;
      end
    end

    count_d = count_q + (PW+1)'(alloc) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= WB_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      d_wvalid_q <= 1'b0;
      d_waddr_q  <= '0;
      d_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      d_wvalid_q <= d_wvalid_d;
      d_waddr_q  <= d_waddr_d;
      d_wdata_q  <= d_wdata_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - randomized bench with queue-based reference model
module tb_dcache_write_buffer;
  import wb_pkg::*;

  localparam int LW = LINE_W;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0]   a;
    logic [LW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          push_valid;
  logic [31:0]   push_addr;
  logic [LW-1:0] push_data;
  logic          push_ready;
  logic [31:0]   lookup_addr;
  logic          lookup_hit;
  logic [LW-1:0] lookup_data;
  logic          empty;
  logic          d_wvalid;
  logic [31:0]   d_waddr;
  logic [LW-1:0] d_wdata;
  logic          d_wready;

  always #5 clk = ~clk;

  dcache_write_buffer #(.Offset_len(6), .Depth(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .push_valid  (push_valid),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .empty       (empty),
    .d_wvalid    (d_wvalid),
    .d_waddr     (d_waddr),
    .d_wdata     (d_wdata),
    .d_wready    (d_wready)
  );

  int n_vec = 0;
  int n_bad = 0;

  ent_t          q[$];
  bit            m_inflight, m_busy;
  int            m_gap;
  logic          m_wvalid;
  logic [31:0]   m_waddr;
  logic [LW-1:0] m_wdata;

  int            arb_wait, arb_busy, busy_len;
  bit            prev_wv, rand_mode, seen_req;
  int            low_run;
  logic [31:0]   issued_a[$];
  logic [LW-1:0] issued_d[$];

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:6], 6'b0};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_inflight = 1'b0;
    m_busy     = 1'b0;
    m_gap      = 0;
    m_wvalid   = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
  endfunction

  function automatic void m_lookup(input logic [31:0] a, output bit hit, output logic [LW-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == line_of(a)) begin
        hit = 1'b1;
        d   = q[i].d;
        break;
      end
    end
  endfunction

  // Applies what the coming clock edge must do, given the inputs now driven.
  function automatic void m_update();
    bit   accept, start, popnow;
    int   tgt, lo;
    ent_t e;
    accept = push_valid && (q.size() != DEPTH);
    start  = !m_inflight && (m_gap == 0) && (q.size() != 0);
    popnow = m_inflight && m_busy && d_wready;
    if (m_inflight && !m_busy && !d_wready) begin
      m_busy   = 1'b1;
      m_wvalid = 1'b0;
    end
    if (start) begin
      m_inflight = 1'b1;
      m_wvalid   = 1'b1;
      m_waddr    = q[0].a;
      m_wdata    = q[0].d;
    end else if (!m_inflight && m_gap > 0) begin
      m_gap--;
    end
    if (accept) begin
      tgt = -1;
      lo  = m_inflight ? 1 : 0;
      for (int i = q.size() - 1; i >= lo; i--) begin
        if (q[i].a == line_of(push_addr)) begin
          tgt = i;
          break;
        end
      end
      if (tgt >= 0) begin
        e      = q[tgt];
        e.d    = push_data;
        q[tgt] = e;
      end else begin
        e.a = line_of(push_addr);
        e.d = push_data;
        q.push_back(e);
      end
    end
    if (popnow) begin
      q.delete(0);
      m_inflight = 1'b0;
      m_busy     = 1'b0;
      m_gap      = 1;
    end
  endfunction

  task automatic step();
    bit            h;
    logic [LW-1:0] d;
    #1;
    m_lookup(lookup_addr, h, d);
    chk("push_ready", LW'(push_ready), LW'(q.size() != DEPTH));
    chk("empty", LW'(empty), LW'((q.size() == 0) && !m_inflight && (m_gap == 0)));
    chk("d_wvalid", LW'(d_wvalid), LW'(m_wvalid));
    chk("d_waddr", LW'(d_waddr), LW'(m_waddr));
    chk("d_wdata", d_wdata, m_wdata);
    chk("lookup_hit", LW'(lookup_hit), LW'(h));
    chk("lookup_data", lookup_data, d);
    m_update();
    @(posedge clk);
    @(negedge clk);
    if (d_wvalid && !prev_wv) begin
      issued_a.push_back(d_waddr);
      issued_d.push_back(d_wdata);
      if (seen_req) chk("req_spacing", LW'(low_run >= 2), LW'(1));
      seen_req = 1'b1;
      busy_len = rand_mode ? int'($urandom_range(1, 8)) : 16;
      arb_wait = 2;
    end else if (arb_wait > 0) begin
      arb_wait--;
      if (arb_wait == 0) begin
        d_wready = 1'b0;
        arb_busy = busy_len;
      end
    end else if (arb_busy > 0) begin
      arb_busy--;
      if (arb_busy == 0) d_wready = 1'b1;
    end
    low_run = d_wvalid ? 0 : low_run + 1;
    prev_wv = d_wvalid;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [LW-1:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    step();
    push_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    push_valid = 1'b0;
    for (int i = 0; i < budget && !empty; i++) step();
    chk("drain_done", LW'(empty), LW'(1));
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && d_wready; i++) step();
    chk("busy_reached", LW'(d_wready), LW'(0));
  endtask

  task automatic clear_log();
    issued_a.delete();
    issued_d.delete();
  endtask

  logic [LW-1:0] dx, da, dy, dp, dq;

  initial begin
    rstn = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
    lookup_addr = '0; d_wready = 1'b1;
    busy_len = 16; rand_mode = 1'b0; seen_req = 1'b0; low_run = 0;
    arb_wait = 0; arb_busy = 0; prev_wv = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_push_ready", LW'(push_ready), LW'(1));
    chk("rst_empty", LW'(empty), LW'(1));
    chk("rst_wvalid", LW'(d_wvalid), LW'(0));
    chk("rst_waddr", LW'(d_waddr), LW'(0));
    chk("rst_wdata", d_wdata, LW'(0));
    step();

    // single line write
    dx = rand_line();
    dx[31:0] = 32'hA5A5_0001;
    push_one(32'h0000_1040, dx);
    step();
    chk("t1_wvalid", LW'(d_wvalid), LW'(1));
    chk("t1_waddr", LW'(d_waddr), LW'(32'h0000_1040));
    chk("t1_word0", LW'(d_wdata[31:0]), LW'(32'hA5A5_0001));
    drain(80);
    chk("t1_count", LW'(issued_a.size()), LW'(1));
    clear_log();

    // fill to capacity, FIFO order
    push_one(32'h100, rand_line());
    push_one(32'h140, rand_line());
    push_one(32'h180, rand_line());
    push_one(32'h1C0, rand_line());
    chk("t2_full", LW'(push_ready), LW'(0));
    drain(200);
    chk("t2_n", LW'(issued_a.size()), LW'(4));
    if (issued_a.size() == 4) begin
      chk("t2_a0", LW'(issued_a[0]), LW'(32'h100));
      chk("t2_a1", LW'(issued_a[1]), LW'(32'h140));
      chk("t2_a2", LW'(issued_a[2]), LW'(32'h180));
      chk("t2_a3", LW'(issued_a[3]), LW'(32'h1C0));
    end
    clear_log();

    // merge into a queued non-head line
    dx = rand_line(); da = rand_line(); dy = rand_line();
    push_one(32'h200, dx);
    push_one(32'h240, da);
    push_one(32'h240, dy);
    chk("t3_model_count", LW'(q.size()), LW'(2));
    lookup_addr = 32'h240;
    #1;
    chk("t3_lookup_y", lookup_data, dy);
    drain(200);
    chk("t3_n", LW'(issued_a.size()), LW'(2));
    if (issued_a.size() == 2) begin
      chk("t3_a0", LW'(issued_a[0]), LW'(32'h200));
      chk("t3_d1", issued_d[1], dy);
    end
    clear_log();

    // same line as the in-flight head allocates a new entry
    dp = rand_line(); dq = rand_line();
    push_one(32'h300, dp);
    wait_busy(20);
    step();
    push_one(32'h300, dq);
    chk("t4_model_count", LW'(q.size()), LW'(2));
    chk("t4_wdata_p", d_wdata, dp);
    lookup_addr = 32'h0000_0318;
    #1;
    chk("t5_hit", LW'(lookup_hit), LW'(1));
    chk("t5_data_q", lookup_data, dq);
    lookup_addr = 32'h400;
    #1;
    chk("t5_miss", LW'(lookup_hit), LW'(0));
    chk("t5_miss_data", lookup_data, LW'(0));
    drain(200);
    chk("t4_n", LW'(issued_d.size()), LW'(2));
    if (issued_d.size() == 2) begin
      chk("t4_d0", issued_d[0], dp);
      chk("t4_d1", issued_d[1], dq);
    end
    clear_log();

    // asynchronous reset during a write
    lookup_addr = 32'h600;
    push_one(32'h600, rand_line());
    push_one(32'h640, rand_line());
    push_one(32'h680, rand_line());
    push_one(32'h6C0, rand_line());
    wait_busy(20);
    step();
    chk("t6_pre_full", LW'(push_ready), LW'(0));
    #3;
    rstn = 1'b1;
    #1;
    chk("t6_wvalid", LW'(d_wvalid), LW'(0));
    chk("t6_push_ready", LW'(push_ready), LW'(1));
    chk("t6_empty", LW'(empty), LW'(1));
    chk("t6_lookup", LW'(lookup_hit), LW'(0));
    @(negedge clk);
    rstn = 1'b0;
    m_reset();
    d_wready = 1'b1; arb_wait = 0; arb_busy = 0; prev_wv = 1'b0;
    clear_log();
    repeat (20) step();
    chk("t6_no_write", LW'(issued_a.size()), LW'(0));

    // randomized traffic over a small set of lines to provoke merges
    rand_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      push_valid  = ($urandom_range(0, 1) == 1);
      push_addr   = 32'h500 + (32'($urandom_range(0, 5)) << 6) + 32'($urandom_range(0, 63));
      push_data   = rand_line();
      lookup_addr = 32'h500 + (32'($urandom_range(0, 6)) << 6) + 32'($urandom_range(0, 63));
      step();
    end
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
